// File: rtl/mouse_pos_tracker.sv
// Purpose: assemble 3-byte PS/2 mouse packets and accumulate clamped absolute X/Y plus button state.
// Latency: byte2 strobe sampled at edge N -> new position/buttons and pkt_valid visible after edge N+1.
// Backpressure: none; bytes arriving during the UPDATE cycle are dropped (upstream spacing is many cycles).
module mouse_pos_tracker #(
   parameter int XMAX           = 799,
   parameter int YMAX           = 599,
   parameter int X_INIT         = 400,
   parameter int Y_INIT         = 300,
   parameter int TIMEOUT_CYCLES = 80000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [11:0] mouse_xpos,
   output logic [11:0] mouse_ypos,
   output logic        mouse_left,
   output logic        mouse_right,
   output logic        pkt_valid,
   output logic        sync_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [11:0]    XMAX_L   = XMAX[11:0];
   localparam logic [11:0]    YMAX_L   = YMAX[11:0];
   localparam logic [11:0]    X_INIT_L = X_INIT[11:0];
   localparam logic [11:0]    Y_INIT_L = Y_INIT[11:0];
   localparam logic [TW-1:0]  TMO_LIM  = TIMEOUT_CYCLES[TW-1:0];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_X = 2'd1,
      WAIT_Y = 2'd2,
      UPDATE = 2'd3
   } state_t;

   state_t state;

   // Raw packet bytes as received; header bit3 (sync) and bit2 carry no payload.
   logic [7:0]    hdr_byte;
   logic [7:0]    x_byte;
   logic [7:0]    y_byte;
   logic [TW-1:0] tmo_cnt;

   logic                timeout_hit;
   logic signed [12:0]  dx_ext;
   logic signed [12:0]  dy_ext;
   logic signed [12:0]  nx;
   logic signed [12:0]  ny;
   logic [11:0]         nx_clamped;
   logic [11:0]         ny_clamped;
   logic                unused_hdr_bits;

   assign unused_hdr_bits = ^hdr_byte[3:2];

   // Saturate a signed 13-bit candidate coordinate into 0..max; never wraps.
   function automatic logic [11:0] clamp_coord(input logic signed [12:0] v,
                                               input logic [11:0]        max);
      logic [11:0] r;
      if (v < 13'sd0)
         r = 12'd0;
      else if (v > $signed({1'b0, max}))
         r = max;
      else
         r = v[11:0];
      return r;
   endfunction

   // Sign-extend deltas (overflow zeroes the axis) and form clamped next positions.
   always_comb begin
      dx_ext = 13'sd0;
      dy_ext = 13'sd0;
      if (!hdr_byte[6])
         dx_ext = {{4{hdr_byte[4]}}, hdr_byte[4], x_byte};
      if (!hdr_byte[7])
         dy_ext = {{4{hdr_byte[5]}}, hdr_byte[5], y_byte};
      // PS/2 Y grows upward while screen Y grows downward, hence the subtraction.
      nx         = $signed({1'b0, mouse_xpos}) + dx_ext;
      ny         = $signed({1'b0, mouse_ypos}) - dy_ext;
      nx_clamped = clamp_coord(nx, XMAX_L);
      ny_clamped = clamp_coord(ny, YMAX_L);
   end

   assign timeout_hit = (tmo_cnt == TMO_LIM);

   // Packet FSM: byte capture, inter-byte timeout, and registered position/button update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hdr_byte    <= 8'd0;
         x_byte      <= 8'd0;
         y_byte      <= 8'd0;
         tmo_cnt     <= '0;
         mouse_xpos  <= X_INIT_L;
         mouse_ypos  <= Y_INIT_L;
         mouse_left  <= 1'b0;
         mouse_right <= 1'b0;
         pkt_valid   <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         pkt_valid <= 1'b0;
         sync_err  <= 1'b0;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (rx_valid) begin
                  if (rx_data[3]) begin
                     hdr_byte <= rx_data;
                     state    <= WAIT_X;
                  end else begin
                     // Not a header: drop it and flag loss of packet alignment.
                     sync_err <= 1'b1;
                  end
               end
            end
            WAIT_X: begin
               if (rx_valid) begin
                  x_byte  <= rx_data;
                  tmo_cnt <= '0;
                  state   <= WAIT_Y;
               end else if (timeout_hit) begin
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT_Y: begin
               if (rx_valid) begin
                  y_byte  <= rx_data;
                  tmo_cnt <= '0;
                  state   <= UPDATE;
               end else if (timeout_hit) begin
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            UPDATE: begin
               mouse_xpos  <= nx_clamped;
               mouse_ypos  <= ny_clamped;
               mouse_left  <= hdr_byte[0];
               mouse_right <= hdr_byte[1];
               pkt_valid   <= 1'b1;
               tmo_cnt     <= '0;
               state       <= IDLE;
            end
            default: begin
               tmo_cnt <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed-vector bench for mouse_pos_tracker: packet assembly, clamping, sync, timeout, overflow, reset.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
// Each scenario task does its own comparisons and steps the shared counters.
module tb_mouse_pos_tracker;

   localparam int TIMEOUT = 80000;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic        mouse_left;
   logic        mouse_right;
   logic        pkt_valid;
   logic        sync_err;

   int tests;
   int fails;
   int pkt_cnt;
   int sync_cnt;

   mouse_pos_tracker dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .mouse_xpos  (mouse_xpos),
      .mouse_ypos  (mouse_ypos),
      .mouse_left  (mouse_left),
      .mouse_right (mouse_right),
      .pkt_valid   (pkt_valid),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Pulse counters: a pulse is counted at the rising edge that ends it.
   always @(posedge clk) begin
      if (pkt_valid === 1'b1) pkt_cnt++;
      if (sync_err === 1'b1) sync_cnt++;
   end

   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      @(negedge clk);
      rx_data  = d;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0, 3);
      send_byte(b1, 3);
      send_byte(b2, 3);
   endtask

   task automatic check_pos(input string name, input int ex, input int ey, input logic el);
      tests++;
      if (mouse_xpos !== ex[11:0]) begin
         fails++;
         $display("FAIL %s xpos: got %0d expected %0d", name, mouse_xpos, ex);
      end
      tests++;
      if (mouse_ypos !== ey[11:0]) begin
         fails++;
         $display("FAIL %s ypos: got %0d expected %0d", name, mouse_ypos, ey);
      end
      tests++;
      if (mouse_left !== el) begin
         fails++;
         $display("FAIL %s left: got %b expected %b", name, mouse_left, el);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_pos("reset", 400, 300, 1'b0);
      tests++;
      if ({mouse_right, pkt_valid, sync_err} !== 3'b000) begin
         fails++;
         $display("FAIL reset flags: got right/pkt/sync=%b expected 000",
                  {mouse_right, pkt_valid, sync_err});
      end
   endtask

   task automatic test_basic();
      int p0;
      do_reset();
      p0 = pkt_cnt;
      send_byte(8'h09, 3);
      send_byte(8'h0A, 3);
      send_byte(8'h05, 0);
      // One edge after the third strobe: UPDATE cycle, nothing applied yet.
      tests++;
      if (pkt_valid !== 1'b0 || mouse_xpos !== 12'd400) begin
         fails++;
         $display("FAIL basic early: got pkt=%b xpos=%0d expected pkt=0 xpos=400",
                  pkt_valid, mouse_xpos);
      end
      @(negedge clk);
      tests++;
      if (pkt_valid !== 1'b1) begin
         fails++;
         $display("FAIL basic pkt_valid: got %b expected 1", pkt_valid);
      end
      check_pos("basic", 410, 295, 1'b1);
      @(negedge clk);
      tests++;
      if (pkt_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic pulse width: got %b expected 0", pkt_valid);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (pkt_cnt - p0 !== 1) begin
         fails++;
         $display("FAIL basic pulse count: got %0d expected 1", pkt_cnt - p0);
      end
   endtask

   task automatic test_negative();
      do_reset();
      send_pkt(8'h18, 8'hF6, 8'h00);
      check_pos("neg_dx", 390, 300, 1'b0);
   endtask

   task automatic test_clamp();
      int ex;
      int ey;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send_pkt(8'h08, 8'h7F, 8'h00);
         ex = 400 + 127 * (i + 1);
         if (ex > 799) ex = 799;
         tests++;
         if (mouse_xpos !== ex[11:0]) begin
            fails++;
            $display("FAIL clamp_x pkt%0d: got %0d expected %0d", i, mouse_xpos, ex);
         end
      end
      for (int i = 0; i < 3; i++) begin
         send_pkt(8'h28, 8'h00, 8'h80);
         ey = 300 + 128 * (i + 1);
         if (ey > 599) ey = 599;
         tests++;
         if (mouse_ypos !== ey[11:0]) begin
            fails++;
            $display("FAIL clamp_y pkt%0d: got %0d expected %0d", i, mouse_ypos, ey);
         end
      end
      check_pos("clamp_final", 799, 599, 1'b0);
      // Negative deltas from the low edge must saturate at zero.
      for (int i = 0; i < 7; i++) send_pkt(8'h18, 8'h80, 8'h7F);
      check_pos("clamp_zero", 0, 0, 1'b0);
   endtask

   task automatic test_sync();
      int p0;
      do_reset();
      p0 = pkt_cnt;
      send_byte(8'h00, 0);
      tests++;
      if (sync_err !== 1'b1) begin
         fails++;
         $display("FAIL sync pulse: got %b expected 1", sync_err);
      end
      @(negedge clk);
      tests++;
      if (sync_err !== 1'b0) begin
         fails++;
         $display("FAIL sync pulse width: got %b expected 0", sync_err);
      end
      check_pos("sync_nochange", 400, 300, 1'b0);
      send_pkt(8'h08, 8'h01, 8'h01);
      check_pos("sync_after", 401, 299, 1'b0);
      tests++;
      if (pkt_cnt - p0 !== 1) begin
         fails++;
         $display("FAIL sync pkt count: got %0d expected 1", pkt_cnt - p0);
      end
   endtask

   task automatic test_timeout();
      int p0;
      int s0;
      do_reset();
      p0 = pkt_cnt;
      s0 = sync_cnt;
      send_byte(8'h08, 2);
      send_byte(8'h05, 0);
      repeat (TIMEOUT + 5) @(negedge clk);
      tests++;
      if (pkt_cnt !== p0 || sync_cnt !== s0) begin
         fails++;
         $display("FAIL timeout gap: got pkt=%0d sync=%0d expected 0 0", pkt_cnt - p0, sync_cnt - s0);
      end
      check_pos("timeout_gap", 400, 300, 1'b0);
      send_pkt(8'h09, 8'h02, 8'h02);
      check_pos("timeout_after", 402, 298, 1'b1);
      tests++;
      if (pkt_cnt - p0 !== 1 || sync_cnt !== s0) begin
         fails++;
         $display("FAIL timeout counts: got pkt=%0d sync=%0d expected 1 0", pkt_cnt - p0, sync_cnt - s0);
      end
   endtask

   task automatic test_overflow_reset();
      int p0;
      do_reset();
      send_pkt(8'h49, 8'h10, 8'h10);
      check_pos("overflow", 400, 284, 1'b1);
      p0 = pkt_cnt;
      send_byte(8'h0B, 2);
      send_byte(8'h20, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_pos("mid_reset", 400, 300, 1'b0);
      repeat (6) @(negedge clk);
      tests++;
      if (pkt_cnt !== p0 || mouse_right !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset pkt: got pkt=%0d right=%b expected 0 0", pkt_cnt - p0, mouse_right);
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      do_reset();
      p0 = pkt_cnt;
      @(negedge clk); rx_data = 8'h09; rx_valid = 1'b1;
      @(negedge clk); rx_data = 8'h0A;
      @(negedge clk); rx_data = 8'h05;
      @(negedge clk); rx_valid = 1'b0;          // UPDATE cycle
      @(negedge clk); rx_data = 8'h0A; rx_valid = 1'b1;
      @(negedge clk); rx_data = 8'h03;
      @(negedge clk); rx_data = 8'h02;
      @(negedge clk); rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_pos("b2b", 413, 293, 1'b0);
      tests++;
      if (mouse_right !== 1'b1 || pkt_cnt - p0 !== 2) begin
         fails++;
         $display("FAIL b2b right/count: got right=%b pkts=%0d expected 1 2", mouse_right, pkt_cnt - p0);
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      pkt_cnt  = 0;
      sync_cnt = 0;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      test_reset();
      test_basic();
      test_negative();
      test_clamp();
      test_sync();
      test_timeout();
      test_overflow_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
